// File: rtl/mvu_pe_popcount_acc.sv
// ---------------------------------------------------------------------------
// mvu_pe_popcount_acc
//
// Purpose:
//   Popcount-and-accumulate back end of a binary MVU processing element.
//   Each accepted beat of SIMD XNOR results is popcounted in one registered
//   stage. The popcounts of SF consecutive beats (one synapse fold) are then
//   summed into a single dot-product result per output neuron. Output
//   backpressure freezes the whole pipe.
//
// Ports:
//   clk      in   rising-edge clock for all state
//   rst_n    in   asynchronous active-low reset
//   in_v     in   in_xnor valid
//   in_rdy   out  beat can be accepted this cycle (combinational)
//   in_xnor  in   [SIMD-1:0] XNOR results, one bit per lane
//   out_v    out  out_acc valid
//   out_rdy  in   consumer accepts out_acc
//   out_acc  out  [TDstI-1:0] accumulated popcount of one fold
// ---------------------------------------------------------------------------
module mvu_pe_popcount_acc #(
    parameter int SIMD  = 4,
    parameter int SF    = 4,
    parameter int TDstI = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_v,
    output logic             in_rdy,
    input  logic [SIMD-1:0]  in_xnor,
    output logic             out_v,
    input  logic             out_rdy,
    output logic [TDstI-1:0] out_acc
);

    localparam int CNT_W = (SF > 1) ? $clog2(SF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SF - 1);

    // The largest possible fold sum is SIMD*SF; it must fit in TDstI bits.
    if ($clog2(SIMD * SF + 1) > TDstI) begin : g_width_check
        $error("mvu_pe_popcount_acc: TDstI too narrow for SIMD*SF");
    end

    function automatic logic [TDstI-1:0] popcount(input logic [SIMD-1:0] bits);
        logic [TDstI-1:0] sum;
        sum = '0;
        for (int i = 0; i < SIMD; i++) begin
            sum = sum + TDstI'(bits[i]);
        end
        return sum;
    endfunction

    logic             pc_v_q, pc_v_d;
    logic [TDstI-1:0] pc_q, pc_d;
    logic [TDstI-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_v_q, out_v_d;
    logic [TDstI-1:0] out_acc_q, out_acc_d;
    logic             adv;
    logic [TDstI-1:0] fold_sum;

    // A result held against a stalled consumer freezes both stages.
    assign adv      = !(out_v_q && !out_rdy);
    assign fold_sum = acc_q + pc_q;

    always_comb begin
        pc_v_d    = pc_v_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_v_d   = out_v_q;
        out_acc_d = out_acc_q;

        // Consumer takes the result; a final sum loading below overrides this.
        if (out_v_q && out_rdy) begin
            out_v_d = 1'b0;
        end

        if (adv) begin
            // ---- stage 1: popcount ----
            pc_v_d = in_v;
            pc_d   = popcount(in_xnor);

            // ---- stage 2: fold accumulator / output register ----
            if (pc_v_q) begin
                if (cnt_q == CNT_LAST) begin
                    out_acc_d = fold_sum;
                    out_v_d   = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else begin
                    acc_d = fold_sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_v_q    <= 1'b0;
            pc_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_v_q   <= 1'b0;
            out_acc_q <= '0;
        end else begin
            pc_v_q    <= pc_v_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_v_q   <= out_v_d;
            out_acc_q <= out_acc_d;
        end
    end

    assign in_rdy  = adv;
    assign out_v   = out_v_q;
    assign out_acc = out_acc_q;

endmodule

// File: doc/mvu_pe_popcount_acc.md
Name: mvu_pe_popcount_acc

Overview:
Downstream neighbour of the XNOR SIMD lanes inside a binary (1-bit weight, 1-bit activation) MVU processing element. Each cycle it takes the SIMD-wide vector of XNOR results and popcounts it in one registered stage. It accumulates the popcounts over SF synapse-fold beats and presents one dot-product result per output neuron on a valid/ready output interface. Output backpressure stalls the whole block.

Parameters:
SIMD, 4, number of XNOR lanes / bits in in_xnor (>=1)
SF, 4, synapse fold: input beats accumulated per output (>=1)
TDstI, 16, accumulator and output word length; must satisfy 2^TDstI > SIMD*SF (elaboration-time assertion)

Ports:
clk  input  1  main clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_v  input  1  in_xnor valid
in_rdy  output  1  block can accept a beat this cycle
in_xnor  input  SIMD  XNOR results, one bit per SIMD lane
out_v  output  1  out_acc valid
out_rdy  input  1  consumer accepts out_acc
out_acc  output  TDstI  accumulated popcount for one output neuron

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - pc_v=0, pc=0, acc=0, fold counter cnt=0, out_v=0, out_acc=0.
  - Reset mid-fold discards the partial sum; there is no carry-over.
- Advance: adv = !(out_v && !out_rdy). in_rdy = adv, purely combinational from out_v/out_rdy. A beat is accepted when in_v && in_rdy.
- Stage 1 (popcount), when adv:
  - pc_v <= in_v.
  - pc <= number of ones in in_xnor, zero-extended to TDstI.
  - When !adv, pc/pc_v hold.
- Stage 2 (fold accumulator), when adv && pc_v:
  - cnt < SF-1: acc <= acc+pc; cnt <= cnt+1.
  - cnt == SF-1: out_acc <= acc+pc; out_v <= 1; acc <= 0; cnt <= 0.
  - SF=1: every beat produces an output and acc stays 0.
- Output register:
  - out_v clears on out_v && out_rdy unless a new final sum loads in the same cycle, in which case out_v stays 1 and out_acc takes the new value (back-to-back, no bubble).
  - out_acc holds stable while out_v && !out_rdy.
- Latency: the final (SF-th) beat accepted at cycle t gives out_v=1 with its sum at cycle t+2.
- Throughput: with out_rdy held at 1, one beat per cycle and one output every SF cycles.
- Bubbles: in_v=0 cycles insert bubbles (pc_v=0) and do not advance cnt.
- Stall: while out_v && !out_rdy, stage 1 and stage 2 freeze. No beat is lost or duplicated. in_xnor is ignored while in_rdy=0.
- Arithmetic: unsigned. Under the parameter constraint no overflow can occur. If the constraint is violated, the sum wraps modulo 2^TDstI.
- cnt width: $clog2(SF), minimum 1 bit. cnt wraps only via the final-beat reset to 0.

Test Plan:
- Reset mid-operation: SIMD=4, SF=4, feed 2 beats, assert rst_n=0 asynchronously between edges -> out_v, acc, cnt, out_acc all 0 immediately. A following full fold of 4'b1111 x4 gives out_acc=16.
- Basic fold, out_rdy=1: beats 4'b1111, 4'b0101, 4'b0000, 4'b1000 -> exactly one out_v pulse, out_acc=7, 2 cycles after the 4th beat is accepted.
- Continuous stream, out_rdy=1: 8 beats of 4'b0111 -> out_v pulses once every 4 cycles, out_acc=12 twice, no bubble between folds.
- Input gaps: same 4 beats as the basic fold with in_v=0 cycles interleaved -> out_acc=7, single pulse, cnt unaffected by gaps.
- Backpressure: hold out_rdy=0 when the first result appears and keep driving in_v=1 -> in_rdy=0 next cycle, out_acc held at its value. Release out_rdy after 5 cycles -> the next fold completes correctly with no lost or duplicated beats (scoreboard against a reference popcount model).
- SF=1, SIMD=1 corner: feed 1,0,1 with out_rdy=1 -> out_acc sequence 1,0,1 on consecutive cycles with out_v continuously 1.
